// File: rtl/vend_pkg.sv
// Shared constants and state encoding for the vending change dispenser.
package vend_pkg;

  localparam int unsigned PRICE_DEFAULT = 20;
  localparam int unsigned DEP_W         = 6;

  localparam logic [DEP_W-1:0] NICKLE  = 6'd5;
  localparam logic [DEP_W-1:0] DIME    = 6'd10;
  localparam logic [DEP_W-1:0] QUARTER = 6'd25;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

endpackage

// File: rtl/vend_pending_buf.sv
// One-entry holding slot for a purchase that arrives while a purchase is running.
// Also keeps the sticky flag recording that an event had to be discarded.
module vend_pending_buf
  import vend_pkg::*;
#(
  parameter int unsigned W = DEP_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load,
  input  logic         take,
  input  logic         drop,
  input  logic [W-1:0] data_in,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         dropped
);

  // Load wins over take so the slot can be refilled in the cycle it is emptied.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid   <= 1'b0;
      data    <= '0;
      dropped <= 1'b0;
    end else begin
      if (load) begin
        valid <= 1'b1;
        data  <= data_in;
      end else if (take) begin
        valid <= 1'b0;
      end
      if (drop) begin
        dropped <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dispense_change.sv
// Release the item, then pay change in dimes before nickles; a purchase lasts 1 + coins cycles.
// One purchase can wait in the pending slot; a further event while that slot is full is dropped.
module dispense_change
  import vend_pkg::*;
#(
  parameter int unsigned PRICE = PRICE_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             exceed_i,
  input  logic [DEP_W-1:0] deposit_i,
  output logic             soda_o,
  output logic             dime_o,
  output logic             nickle_o,
  output logic             busy_o,
  output logic             overflow_o
);

  localparam logic [DEP_W-1:0] PRICE_W = DEP_W'(PRICE);

  state_t           state_q, state_d;
  logic [DEP_W-1:0] change_q, change_d;
  logic [DEP_W-1:0] coin, remain;
  logic             event_ok, exiting;
  logic             pend_load, pend_take, pend_drop, pend_vld;
  logic [DEP_W-1:0] pend_dat;

  assign event_ok = exceed_i && (deposit_i >= PRICE_W);
  assign coin     = (change_q >= DIME) ? DIME : NICKLE;
  assign remain   = change_q - coin;
  // Last busy cycle: nothing left to pay after the vend, or the coin now leaving drops change below a nickle.
  assign exiting  = ((state_q == VEND)   && (change_q < NICKLE)) ||
                    ((state_q == CHANGE) && (remain   < NICKLE));

  vend_pending_buf #(.W(DEP_W)) u_pending (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load    (pend_load),
    .take    (pend_take),
    .drop    (pend_drop),
    .data_in (deposit_i),
    .valid   (pend_vld),
    .data    (pend_dat),
    .dropped (overflow_o)
  );

  always_comb begin
    state_d   = state_q;
    change_d  = change_q;
    pend_load = 1'b0;
    pend_take = 1'b0;
    pend_drop = 1'b0;

    case (state_q)
      IDLE: begin
        if (event_ok) begin
          state_d  = VEND;
          change_d = deposit_i - PRICE_W;
        end
      end
      VEND:    state_d  = CHANGE;
      CHANGE:  change_d = remain;
      default: state_d  = IDLE;
    endcase

    if (state_q != IDLE) begin
      if (exiting) begin
        // The waiting purchase goes first; a fresh event takes its place in the slot.
        if (pend_vld) begin
          state_d   = VEND;
          change_d  = pend_dat - PRICE_W;
          pend_take = 1'b1;
          pend_load = event_ok;
        end else if (event_ok) begin
          state_d  = VEND;
          change_d = deposit_i - PRICE_W;
        end else begin
          state_d  = IDLE;
          change_d = '0;
        end
      end else if (event_ok) begin
        pend_load = !pend_vld;
        pend_drop = pend_vld;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      change_q <= '0;
    end else begin
      state_q  <= state_d;
      change_q <= change_d;
    end
  end

  assign soda_o   = (state_q == VEND);
  assign dime_o   = (state_q == CHANGE) && (change_q >= DIME);
  assign nickle_o = (state_q == CHANGE) && (change_q <  DIME);
  assign busy_o   = (state_q != IDLE);

endmodule

// File: doc/dispense_change.md
DISPENSE_CHANGE -- requirements
Module: dispense_change

Interface
REQ-001 SHALL have parameter PRICE, default 20, meaning item price in cents.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port exceed_i  input  1  purchase event from coin accepting stage (deposit >= PRICE this cycle).
REQ-005 SHALL have port deposit_i  input  6  deposited cents from accepting stage, valid when exceed_i=1 (range PRICE..40).
REQ-006 SHALL have port soda_o  output  1  item release pulse, one cycle per purchase.
REQ-007 SHALL have port dime_o  output  1  dispense one 10-cent coin this cycle.
REQ-008 SHALL have port nickle_o  output  1  dispense one 5-cent coin this cycle.
REQ-009 SHALL have port busy_o  output  1  purchase in progress (state != IDLE).
REQ-010 SHALL have port overflow_o  output  1  sticky: a purchase event was dropped.

Function
REQ-011 SHALL treat every cycle with exceed_i=1 as one distinct purchase event; no edge detection.
REQ-012 SHALL ignore an event whose deposit_i < PRICE (no state change, no overflow).
REQ-013 SHALL implement FSM states IDLE, VEND, CHANGE.
REQ-014 IDLE: event sampled at edge N -> VEND in cycle N+1, active change register = deposit_i - PRICE.
REQ-015 VEND: soda_o=1 for exactly one cycle; next state CHANGE if change >= 5, else exit (REQ-018).
REQ-016 CHANGE: each cycle asserts exactly one coin output: dime_o if change >= 10, else nickle_o; change decrements by coin value at edge.
REQ-017 CHANGE: when remaining change after the current coin is < 5, exit after this cycle; residue < 5 is discarded.
REQ-018 Exit: if pending valid -> VEND with pending loaded as active; else if event this cycle -> VEND with that event; else IDLE.
REQ-019 SHALL hold a one-entry pending buffer; an event while busy and not exiting loads pending if empty.
REQ-020 Event in exit cycle with pending full: pending -> active, new event -> pending; nothing dropped.
REQ-021 Event while busy, not exiting, pending full: event dropped, overflow_o set and held until reset.
REQ-022 soda_o, dime_o, nickle_o SHALL be mutually exclusive; never two asserted in one cycle.
REQ-023 Outputs SHALL be decoded from registered state/change only (no combinational path from inputs).
REQ-024 Change arithmetic 6-bit unsigned; max change 40-PRICE = 20 -> at most 2 coins.
REQ-025 Latency: event at edge N -> soda_o in N+1 -> first coin in N+2; purchase duration 1 + coin count cycles.

Reset
REQ-026 rst_ni=0 at an edge SHALL force IDLE, change=0, pending empty, overflow_o=0; soda_o, dime_o, nickle_o, busy_o = 0 next cycle.
REQ-027 Reset mid-purchase SHALL abandon remaining coins and pending event; exceed_i ignored in reset cycles.

Structure
REQ-028 Package vend_pkg SHALL hold PRICE default, coin value constants (NICKLE=5, DIME=10, QUARTER=25) and the state enum.
REQ-029 Pending buffer SHALL be sub-module vend_pending_buf (load, take, valid, data, drop flag).

Verification
REQ-030 deposit_i=20 with exceed_i=1 one cycle -> soda_o next cycle, no coins, busy_o 1 cycle, then IDLE.
REQ-031 deposit_i=35 -> soda_o, then dime_o, then nickle_o on consecutive cycles; total change 15.
REQ-032 deposit_i=40, then deposit_i=25 on the next cycle -> soda, dime, dime, soda, nickle; no overflow.
REQ-033 Three events on consecutive cycles, deposits 40, 40, 40 -> third dropped, overflow_o=1 sticky, two purchases completed.
REQ-034 rst_ni=0 during CHANGE after deposit 40 -> no further coins, busy_o=0, overflow_o=0.
REQ-035 exceed_i=1 with deposit_i=15 -> ignored, busy_o stays 0.
